chargen_fifo_writer: RTL

- Producer-side sequencer for the byte FIFO. Generates the RFC 864 character-generator stream and pushes it into the FIFO write port under `n_full` backpressure.
- Emits lines of printable ASCII; each successive line starts one character later in the rotating pattern.
- Starts and stops on command. Stopping only ever happens at a line boundary.

---
 rtl/chargen_fifo_writer.sv | 117 +++++++++++
 1 files changed

// File: rtl/chargen_fifo_writer.sv
// Character-generator producer: streams rotating printable-ASCII lines into a byte FIFO under n_full backpressure.
// Line terminator is CR LF when CHARGEN_CR_EN is defined, LF only otherwise.
module chargen_fifo_writer #(
  parameter int         LINE_LEN   = 72,
  parameter logic [7:0] FIRST_CHAR = 8'h20,
  parameter logic [7:0] LAST_CHAR  = 8'h7E
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        n_en,
  input  logic        n_full,
  output logic        n_wr,
  output logic [7:0]  wr_data,
  output logic        n_busy,
  output logic [15:0] lines_done
);

  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHAR = 2'd1,
`ifdef CHARGEN_CR_EN
    S_CR   = 2'd3,
`endif
    S_LF   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       cur_char_q, cur_char_d;
  logic [7:0]       line_start_q, line_start_d;
  logic [15:0]      lines_done_q, lines_done_d;
  logic             acc;

  function automatic logic [7:0] next_char(input logic [7:0] c);
    return (c == LAST_CHAR) ? FIRST_CHAR : 8'(c + 8'd1);
  endfunction

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cur_char_d   = cur_char_q;
    line_start_d = line_start_q;
    lines_done_d = lines_done_q;
    acc          = (state_q != S_IDLE) && n_full;
    n_wr         = ~acc;
    n_busy       = (state_q == S_IDLE);
    wr_data      = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (!n_en) begin
          state_d    = S_CHAR;
          cur_char_d = line_start_q;
          col_d      = '0;
        end
      end
      S_CHAR: begin
        wr_data = cur_char_q;
        if (acc) begin
          col_d      = COL_W'(col_q + 1'b1);
          cur_char_d = next_char(cur_char_q);
          if (col_q == COL_LAST) begin
`ifdef CHARGEN_CR_EN
            state_d = S_CR;
`else
            state_d = S_LF;
`endif
          end
        end
      end
`ifdef CHARGEN_CR_EN
      S_CR: begin
        wr_data = 8'h0D;
        if (acc) state_d = S_LF;
      end
`endif
      S_LF: begin
        wr_data = 8'h0A;
        if (acc) begin
          lines_done_d = lines_done_q + 16'd1;
          line_start_d = next_char(line_start_q);
          col_d        = '0;
          // n_en is only honoured here, so a stop always lands on a line boundary
          if (!n_en) begin
            state_d    = S_CHAR;
            cur_char_d = next_char(line_start_q);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      cur_char_q   <= FIRST_CHAR;
      line_start_q <= FIRST_CHAR;
      lines_done_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cur_char_q   <= cur_char_d;
      line_start_q <= line_start_d;
      lines_done_q <= lines_done_d;
    end
  end

  assign lines_done = lines_done_q;

endmodule
